// File: rtl/counter_pkg.sv
// Shared types and helpers for the multi-channel counter bank.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP_UP   = 2'b00,
    SAT_UP    = 2'b01,
    WRAP_DOWN = 2'b10,
    SAT_DOWN  = 2'b11
  } cnt_mode_e;

  localparam cnt_mode_e RST_MODE = WRAP_UP;

  function automatic logic is_down(input cnt_mode_e mode);
    return mode[1];
  endfunction

  function automatic logic is_wrap(input cnt_mode_e mode);
    return ~mode[0];
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One independent counter channel: programmable limit/mode, load, tc pulse, sticky ovf.
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [1:0]       cfg_mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] limit_q, limit_d, cnt_d, start, term;
  cnt_mode_e        mode_q, mode_d, new_mode;
  logic             tc_d, ovf_d, ovf_set;

  always_comb begin
    new_mode = cnt_mode_e'(cfg_mode);
    start    = is_down(mode_q) ? limit_q : '0;
    term     = is_down(mode_q) ? '0 : limit_q;
    cnt_d    = cnt;
    limit_d  = limit_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    ovf_set  = 1'b0;
    if (cfg_we) begin
      // Restart from the start value of the newly written mode/limit.
      limit_d = cfg_limit;
      mode_d  = new_mode;
      cnt_d   = is_down(new_mode) ? cfg_limit : '0;
    end else if (ld) begin
      cnt_d = (ld_val > limit_q) ? limit_q : ld_val;
    end else if (en) begin
      if (cnt != term) begin
        cnt_d = is_down(mode_q) ? cnt - 1'b1 : cnt + 1'b1;
      end else begin
        ovf_set = 1'b1;
        if (is_wrap(mode_q)) begin
          cnt_d = start;
          tc_d  = 1'b1;
        end
      end
    end
    // A set event in the same cycle as a clear keeps the flag high.
    ovf_d = ovf_set | (ovf & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      limit_q <= '1;
      mode_q  <= RST_MODE;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      tc      <= tc_d;
      ovf     <= ovf_d;
    end
  end

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of CH independent WIDTH-bit counters sharing one configuration port.
module multi_channel_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_limit,
  input  logic [1:0]          cfg_mode,
  input  logic [CH-1:0]       ld,
  input  logic [WIDTH-1:0]    ld_val,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       clr_ovf,
  output logic [CH*WIDTH-1:0] cnt,
  output logic [CH-1:0]       tc,
  output logic [CH-1:0]       ovf
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CHW'(i));

    counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (ch_we),
      .cfg_limit(cfg_limit),
      .cfg_mode (cfg_mode),
      .ld       (ld[i]),
      .ld_val   (ld_val),
      .en       (en[i]),
      .clr_ovf  (clr_ovf[i]),
      .cnt      (cnt[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .ovf      (ovf[i])
    );
  end

endmodule
